// File: rtl/systolic_feeder_pkg.sv
// ----------------------------------------------------------------------------
// feeder_pkg
// Shared definitions for the systolic array feeder:
//   - FEEDER_LANES / FEEDER_DW : default lane count and per-lane byte width
//   - feeder_state_t           : controller state enumeration
//   - cntWidth()               : counter width that stays legal when n == 1
// ----------------------------------------------------------------------------
package feeder_pkg;

    localparam int FEEDER_LANES = 4;
    localparam int FEEDER_DW    = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } feeder_state_t;

    // A single-lane feeder still needs a 1-bit counter, so never return 0.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// ----------------------------------------------------------------------------
// systolic_feeder_if
// Upstream beat channel into the feeder (valid/ready handshake).
//   s_valid : upstream beat is valid
//   s_ready : feeder accepts a beat this cycle
//   s_data  : one DW-bit byte per lane, lane i at [i*DW +: DW]
//   s_last  : final activation beat of a job
// Modports: master (upstream source), slave (feeder).
// ----------------------------------------------------------------------------
interface systolic_feeder_if
    import feeder_pkg::*;
#(
    parameter int LANES = FEEDER_LANES,
    parameter int DW    = FEEDER_DW
) ();

    logic                  s_valid;
    logic                  s_ready;
    logic [LANES*DW-1:0]   s_data;
    logic                  s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/systolic_feeder_skew_delay.sv
// ----------------------------------------------------------------------------
// skew_delay
// One lane of the activation skew: a DEPTH-stage shift register carrying a
// DW-bit byte plus its valid bit. Shifts only while i_en is high.
//   clk    : clock
//   rst    : asynchronous active-low reset, clears every stage
//   i_en   : shift enable
//   i_data : byte entering stage 0
//   i_vld  : valid entering stage 0
//   o_data : byte leaving the last stage (DEPTH cycles after entry)
//   o_vld  : valid leaving the last stage
// ----------------------------------------------------------------------------
module skew_delay #(
    parameter int DW    = 8,
    parameter int DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic [DW-1:0] i_data,
    input  logic          i_vld,
    output logic [DW-1:0] o_data,
    output logic          o_vld
);

    logic [DEPTH-1:0][DW-1:0] r_data;
    logic [DEPTH-1:0]         r_vld;

    // Shift chain: stage 0 takes the new byte, every other stage takes its
    // predecessor. Written as a loop so DEPTH=1 needs no special case.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_vld  <= '0;
        end else if (i_en) begin
            r_data[0] <= i_data;
            r_vld[0]  <= i_vld;
            for (int k = 1; k < DEPTH; k++) begin
                r_data[k] <= r_data[k-1];
                r_vld[k]  <= r_vld[k-1];
            end
        end
    end

    assign o_data = r_data[DEPTH-1];
    assign o_vld  = r_vld[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// ----------------------------------------------------------------------------
// systolic_feeder
// Feeds a LANES-row systolic array: first loads LANES weight beats onto the
// PE in_b bus, then streams activation beats onto in_a with lane i delayed
// by i+1 cycles, then drains the skew lines and pulses done.
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   start     : pulse in IDLE to begin a job (ignored elsewhere)
//   s_if      : upstream beat channel (slave side)
//   out_a     : skewed activations, lane i at [i*DW +: DW]
//   out_a_vld : per-lane valid for out_a
//   out_b     : registered weight beat
//   out_b_en  : weight-load enable, high the cycle after a LOAD beat
//   busy      : controller not in IDLE
//   done      : one-cycle pulse on the last DRAIN cycle
// ----------------------------------------------------------------------------
module systolic_feeder
    import feeder_pkg::*;
#(
    parameter int LANES = FEEDER_LANES,
    parameter int DW    = FEEDER_DW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    systolic_feeder_if.slave    s_if,
    output logic [LANES*DW-1:0] out_a,
    output logic [LANES-1:0]    out_a_vld,
    output logic [LANES*DW-1:0] out_b,
    output logic                out_b_en,
    output logic                busy,
    output logic                done
);

    localparam int            CW       = cntWidth(LANES);
    localparam logic [CW-1:0] CNT_LAST = CW'(LANES - 1);

    feeder_state_t r_state;
    feeder_state_t w_nextState;

    logic [CW-1:0]            r_weightCnt;
    logic [CW-1:0]            r_drainCnt;
    logic [LANES*DW-1:0]      r_outB;
    logic                     r_outBEn;

    logic                     w_ready;
    logic                     w_accept;
    logic                     w_skewEn;
    logic                     w_inVld;
    logic [LANES-1:0][DW-1:0] w_inLane;
    logic [LANES-1:0][DW-1:0] w_laneData;
    logic [LANES-1:0]         w_laneVld;

    assign w_accept = s_if.s_valid & w_ready;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and state-derived outputs. start matters only in IDLE and
    // s_last only in STREAM; LOAD ends purely on the weight count.
    always_comb begin
        w_nextState = r_state;
        w_ready     = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_nextState = LOAD;
                end
            end
            LOAD: begin
                w_ready = 1'b1;
                if (w_accept && (r_weightCnt == CNT_LAST)) begin
                    w_nextState = STREAM;
                end
            end
            STREAM: begin
                w_ready = 1'b1;
                if (w_accept && s_if.s_last) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drainCnt == CNT_LAST) begin
                    done        = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign s_if.s_ready = w_ready;

    // Weight-beat counter: advances only on accepted LOAD beats and wraps
    // to 0 on the beat that completes the load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_weightCnt <= '0;
        end else if ((r_state == LOAD) && w_accept) begin
            r_weightCnt <= (r_weightCnt == CNT_LAST) ? '0 : r_weightCnt + 1'b1;
        end
    end

    // Drain counter: counts the LANES bubble cycles needed to flush the
    // deepest skew line; held at 0 outside DRAIN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drainCnt <= '0;
        end else if ((r_state == DRAIN) && (r_drainCnt != CNT_LAST)) begin
            r_drainCnt <= r_drainCnt + 1'b1;
        end else begin
            r_drainCnt <= '0;
        end
    end

    // Weight register: captures each accepted LOAD beat and holds it after
    // the load, with the enable high only in the cycle following a beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_outB   <= '0;
            r_outBEn <= 1'b0;
        end else begin
            r_outBEn <= (r_state == LOAD) && w_accept;
            if ((r_state == LOAD) && w_accept) begin
                r_outB <= s_if.s_data;
            end
        end
    end

    assign out_b    = r_outB;
    assign out_b_en = r_outBEn;

    // Skew lines run every STREAM/DRAIN cycle; any cycle without an accepted
    // STREAM beat pushes a zero bubble so stale bytes never reach the PEs.
    assign w_skewEn = (r_state == STREAM) || (r_state == DRAIN);
    assign w_inVld  = (r_state == STREAM) && w_accept;
    assign w_inLane = w_inVld ? s_if.s_data : '0;

    for (genvar g = 0; g < LANES; g++) begin : gLane
        skew_delay #(
            .DW    (DW),
            .DEPTH (g + 1)
        ) uSkew (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_skewEn),
            .i_data (w_inLane[g]),
            .i_vld  (w_inVld),
            .o_data (w_laneData[g]),
            .o_vld  (w_laneVld[g])
        );
    end

    assign out_a     = w_laneData;
    assign out_a_vld = w_laneVld;

endmodule

// File: tb/tb_systolic_feeder.sv
// ----------------------------------------------------------------------------
// tb_systolic_feeder
// Self-checking bench for systolic_feeder (LANES=4, DW=8). A job-level model
// tracks the phase (idle / load n / stream / drain n) and schedules each
// accepted activation byte onto a per-cycle expectation table at
// acceptance + lane + 1.
// ----------------------------------------------------------------------------
module tb_systolic_feeder;

    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int W     = LANES * DW;
    localparam int NCYC  = 8192;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [W-1:0]     out_a;
    logic [LANES-1:0] out_a_vld;
    logic [W-1:0]     out_b;
    logic             out_b_en;
    logic             busy;
    logic             done;

    systolic_feeder_if #(.LANES(LANES), .DW(DW)) sIf ();

    systolic_feeder #(.LANES(LANES), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .s_if      (sIf),
        .out_a     (out_a),
        .out_a_vld (out_a_vld),
        .out_b     (out_b),
        .out_b_en  (out_b_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model state: phase 0 idle, 1 load, 2 stream, 3 drain.
    int               mPhase = 0;
    int               mCount = 0;
    int               mCyc   = 0;
    logic [W-1:0]     mOutB  = '0;
    logic             mOutBEn = 1'b0;
    logic [W-1:0]     expData [NCYC];
    logic [LANES-1:0] expVld  [NCYC];

    // Drive the upstream inputs for the coming cycle.
    task automatic applyStimulus(input logic st, input logic v, input logic [W-1:0] d, input logic l);
        start       = st;
        sIf.s_valid = v;
        sIf.s_data  = d;
        sIf.s_last  = l;
    endtask

    // Advance the job model across one rising edge using the inputs present.
    task automatic modelEdge();
        logic acc;
        acc     = sIf.s_valid && (mPhase == 1 || mPhase == 2);
        mOutBEn = (mPhase == 1) && acc;
        case (mPhase)
            0: if (start) begin mPhase = 1; mCount = 0; end
            1: if (acc) begin
                mOutB  = sIf.s_data;
                mCount = mCount + 1;
                if (mCount == LANES) begin mPhase = 2; mCount = 0; end
            end
            2: if (acc) begin
                for (int i = 0; i < LANES; i++) begin
                    expData[mCyc+i+1][i*DW +: DW] = sIf.s_data[i*DW +: DW];
                    expVld[mCyc+i+1][i]           = 1'b1;
                end
                if (sIf.s_last) begin mPhase = 3; mCount = 0; end
            end
            default: begin
                if (mCount == LANES - 1) begin mPhase = 0; mCount = 0; end
                else mCount = mCount + 1;
            end
        endcase
        mCyc = mCyc + 1;
    endtask

    // Reset discards the job and every byte still in flight.
    task automatic modelReset();
        mPhase  = 0;
        mCount  = 0;
        mOutB   = '0;
        mOutBEn = 1'b0;
        for (int c = mCyc; c <= mCyc + LANES + 1; c++) begin
            expData[c] = '0;
            expVld[c]  = '0;
        end
    endtask

    // One clock: model follows the edge, then settle before sampling.
    task automatic advance();
        @(posedge clk);
        if (rst) modelEdge();
        else     mCyc = mCyc + 1;
        #2;
    endtask

    // Start a job and load four random weights (stimulus only).
    task automatic startAndLoad();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        advance();
        for (int k = 0; k < LANES; k++) begin
            applyStimulus(1'b0, 1'b1, W'($urandom), 1'b0);
            advance();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic test_reset();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        #1 rst = 1'b0;
        #1;
        nCompared++; if (out_a !== '0)     begin nMismatched++; $display("[TB] FAIL reset_out_a: got %h want 0", out_a); end
        nCompared++; if (out_a_vld !== '0) begin nMismatched++; $display("[TB] FAIL reset_out_a_vld: got %b want 0", out_a_vld); end
        nCompared++; if (out_b !== '0)     begin nMismatched++; $display("[TB] FAIL reset_out_b: got %h want 0", out_b); end
        nCompared++; if (out_b_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_b_en: got %b want 0", out_b_en); end
        nCompared++; if (sIf.s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_s_ready: got %b want 0", sIf.s_ready); end
        nCompared++; if (busy !== 1'b0 || done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy_done: got %b%b want 00", busy, done); end
        modelReset();
        advance();
        advance();
        // First start right after release must be taken on the next edge.
        rst = 1'b1;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        advance();
        nCompared++; if (busy !== 1'b1 || sIf.s_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL first_start: busy/ready got %b%b want 11", busy, sIf.s_ready); end
        nCompared++; if (out_b_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL first_start_b_en: got %b want 0", out_b_en); end
    endtask

    task automatic test_weight_load();
        logic [W-1:0] wt [LANES];
        wt[0] = 32'h04030201; wt[1] = 32'h08070605; wt[2] = 32'h0C0B0A09; wt[3] = 32'h100F0E0D;
        for (int k = 0; k < LANES; k++) begin
            applyStimulus(1'b0, 1'b1, wt[k], 1'b0);
            advance();
            nCompared++; if (out_b_en !== 1'b1) begin nMismatched++; $display("[TB] FAIL load_b_en[%0d]: got %b want 1", k, out_b_en); end
            nCompared++; if (out_b !== wt[k])   begin nMismatched++; $display("[TB] FAIL load_out_b[%0d]: got %h want %h", k, out_b, wt[k]); end
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        advance();
        nCompared++; if (out_b_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL load_b_en_off: got %b want 0", out_b_en); end
        nCompared++; if (out_b !== wt[3])   begin nMismatched++; $display("[TB] FAIL load_hold_b: got %h want %h", out_b, wt[3]); end
        nCompared++; if (busy !== 1'b1 || sIf.s_ready !== 1'b1 || out_a_vld !== '0) begin nMismatched++; $display("[TB] FAIL stream_entry: busy/ready/vld got %b%b%b", busy, sIf.s_ready, out_a_vld); end
    endtask

    task automatic test_skew();
        logic [W-1:0] beat;
        logic [DW-1:0] bv;
        beat = 32'h44332211;
        applyStimulus(1'b0, 1'b1, beat, 1'b1);
        advance();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        for (int t = 1; t <= LANES; t++) begin
            bv = beat[(t-1)*DW +: DW];
            nCompared++; if (out_a_vld !== LANES'(1 << (t-1))) begin nMismatched++; $display("[TB] FAIL skew_vld[+%0d]: got %b want %b", t, out_a_vld, LANES'(1 << (t-1))); end
            nCompared++; if (out_a[(t-1)*DW +: DW] !== bv) begin nMismatched++; $display("[TB] FAIL skew_lane[+%0d]: got %h want %h", t, out_a[(t-1)*DW +: DW], bv); end
            nCompared++; if (out_a !== expData[mCyc]) begin nMismatched++; $display("[TB] FAIL skew_out_a[+%0d]: got %h want %h", t, out_a, expData[mCyc]); end
            nCompared++; if (done !== (t == LANES)) begin nMismatched++; $display("[TB] FAIL skew_done[+%0d]: got %b want %b", t, done, (t == LANES)); end
            nCompared++; if (sIf.s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL drain_ready[+%0d]: got %b want 0", t, sIf.s_ready); end
            advance();
        end
        nCompared++; if (done !== 1'b0 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL skew_idle: done/busy got %b%b want 00", done, busy); end
    endtask

    task automatic test_bubbles();
        logic          sv [3];
        logic [W-1:0]  sd [3];
        logic          sl [3];
        sv[0] = 1'b1; sd[0] = 32'h01010101; sl[0] = 1'b0;
        sv[1] = 1'b0; sd[1] = 32'hDEADBEEF; sl[1] = 1'b0;
        sv[2] = 1'b1; sd[2] = 32'h02020202; sl[2] = 1'b1;
        startAndLoad();
        for (int c = 0; c < 3 + LANES + 1; c++) begin
            nCompared++; if (out_a !== expData[mCyc])    begin nMismatched++; $display("[TB] FAIL bubble_out_a[%0d]: got %h want %h", c, out_a, expData[mCyc]); end
            nCompared++; if (out_a_vld !== expVld[mCyc]) begin nMismatched++; $display("[TB] FAIL bubble_vld[%0d]: got %b want %b", c, out_a_vld, expVld[mCyc]); end
            if (c < 3) applyStimulus(1'b0, sv[c], sd[c], sl[c]);
            else       applyStimulus(1'b0, 1'b0, '0, 1'b0);
            advance();
        end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL bubble_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_ignored_inputs();
        logic [W-1:0] w;
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        advance();
        for (int k = 0; k < LANES; k++) begin
            w = W'($urandom);
            applyStimulus(1'b0, 1'b1, w, (k == 1));
            advance();
            nCompared++; if (out_b_en !== 1'b1 || out_b !== w) begin nMismatched++; $display("[TB] FAIL ign_load[%0d]: en/b got %b/%h want 1/%h", k, out_b_en, out_b, w); end
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            advance();
            nCompared++; if (busy !== 1'b1 || sIf.s_ready !== 1'b1 || out_b_en !== 1'b0 || out_a_vld !== '0) begin
                nMismatched++; $display("[TB] FAIL ign_start[%0d]: busy/ready/b_en/vld got %b%b%b%b want 1100", k, busy, sIf.s_ready, out_b_en, out_a_vld);
            end
        end
        applyStimulus(1'b0, 1'b1, W'($urandom), 1'b1);
        for (int c = 0; c <= LANES; c++) begin
            advance();
            applyStimulus(1'b0, 1'b0, '0, 1'b0);
            nCompared++; if (out_a !== expData[mCyc] || out_a_vld !== expVld[mCyc]) begin nMismatched++; $display("[TB] FAIL ign_stream[%0d]: got %h/%b want %h/%b", c, out_a, out_a_vld, expData[mCyc], expVld[mCyc]); end
            nCompared++; if (done !== (mPhase == 3 && mCount == LANES - 1)) begin nMismatched++; $display("[TB] FAIL ign_done[%0d]: got %b", c, done); end
        end
    endtask

    task automatic test_reset_mid_job();
        startAndLoad();
        applyStimulus(1'b0, 1'b1, W'($urandom), 1'b0);
        advance();
        applyStimulus(1'b0, 1'b1, W'($urandom), 1'b1);
        advance();
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        advance();
        #3 rst = 1'b0;
        #1;
        nCompared++; if (out_a !== '0 || out_a_vld !== '0) begin nMismatched++; $display("[TB] FAIL midrst_a: got %h/%b want 0/0", out_a, out_a_vld); end
        nCompared++; if (out_b !== '0 || out_b_en !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_b: got %h/%b want 0/0", out_b, out_b_en); end
        nCompared++; if (busy !== 1'b0 || done !== 1'b0 || sIf.s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL midrst_ctl: busy/done/ready got %b%b%b want 000", busy, done, sIf.s_ready); end
        modelReset();
        for (int k = 0; k < 3; k++) begin
            advance();
            nCompared++; if (done !== 1'b0 || out_a_vld !== '0) begin nMismatched++; $display("[TB] FAIL midrst_hold[%0d]: done/vld got %b/%b want 0/0", k, done, out_a_vld); end
        end
        rst = 1'b1;
        startAndLoad();
        for (int c = 0; c < 12; c++) begin
            if (c < 3) applyStimulus(1'b0, 1'b1, W'($urandom), (c == 2));
            else       applyStimulus(1'b0, 1'b0, '0, 1'b0);
            advance();
            nCompared++; if (out_a !== expData[mCyc] || out_a_vld !== expVld[mCyc]) begin nMismatched++; $display("[TB] FAIL rerun_a[%0d]: got %h/%b want %h/%b", c, out_a, out_a_vld, expData[mCyc], expVld[mCyc]); end
            nCompared++; if (done !== (mPhase == 3 && mCount == LANES - 1) || busy !== (mPhase != 0)) begin nMismatched++; $display("[TB] FAIL rerun_ctl[%0d]: done/busy got %b%b", c, done, busy); end
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, W'($urandom), 1'b1);
            advance();
            nCompared++; if (sIf.s_ready !== 1'b0 || out_a_vld !== '0 || busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_idle[%0d]: ready/vld/busy got %b/%b/%b", k, sIf.s_ready, out_a_vld, busy); end
        end
        startAndLoad();
        applyStimulus(1'b0, 1'b1, W'($urandom), 1'b1);
        advance();
        for (int c = 0; c < LANES; c++) begin
            nCompared++; if (sIf.s_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_drain_ready[%0d]: got %b want 0", c, sIf.s_ready); end
            nCompared++; if (out_a !== expData[mCyc] || out_a_vld !== expVld[mCyc]) begin nMismatched++; $display("[TB] FAIL bp_drain_a[%0d]: got %h/%b want %h/%b", c, out_a, out_a_vld, expData[mCyc], expVld[mCyc]); end
            applyStimulus(1'b0, 1'b1, W'($urandom), 1'b0);
            advance();
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        nCompared++; if (busy !== 1'b0 || out_a_vld !== '0) begin nMismatched++; $display("[TB] FAIL bp_end: busy/vld got %b/%b want 0/0", busy, out_a_vld); end
    endtask

    task automatic test_random_jobs();
        int  budget;
        int  streamed;
        logic v, l;
        for (int job = 0; job < 20; job++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b0);
            advance();
            budget   = 0;
            streamed = 0;
            while (mPhase != 0 && budget < 300) begin
                nCompared++; if (out_a !== expData[mCyc])    begin nMismatched++; $display("[TB] FAIL rnd_out_a[%0d]: got %h want %h", job, out_a, expData[mCyc]); end
                nCompared++; if (out_a_vld !== expVld[mCyc]) begin nMismatched++; $display("[TB] FAIL rnd_vld[%0d]: got %b want %b", job, out_a_vld, expVld[mCyc]); end
                nCompared++; if (out_b !== mOutB || out_b_en !== mOutBEn) begin nMismatched++; $display("[TB] FAIL rnd_b[%0d]: got %h/%b want %h/%b", job, out_b, out_b_en, mOutB, mOutBEn); end
                nCompared++; if (done !== (mPhase == 3 && mCount == LANES - 1)) begin nMismatched++; $display("[TB] FAIL rnd_done[%0d]: got %b", job, done); end
                nCompared++; if (busy !== 1'b1 || sIf.s_ready !== (mPhase == 1 || mPhase == 2)) begin nMismatched++; $display("[TB] FAIL rnd_ctl[%0d]: busy/ready got %b%b", job, busy, sIf.s_ready); end
                v = ($urandom_range(0, 9) < 7);
                l = ($urandom_range(0, 5) == 0) || (streamed >= 12);
                if (mPhase == 2 && v) streamed++;
                applyStimulus(($urandom_range(0, 7) == 0), v, W'($urandom), l);
                advance();
                budget++;
            end
            if (budget >= 300) begin
                nCompared++; nMismatched++;
                $display("[TB] FAIL rnd_timeout[%0d]: job still active after %0d cycles", job, budget);
            end
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                applyStimulus(1'b0, $urandom_range(0, 1) == 1, W'($urandom), 1'b0);
                advance();
                nCompared++; if (busy !== 1'b0 || out_a_vld !== '0) begin nMismatched++; $display("[TB] FAIL rnd_gap[%0d]: busy/vld got %b/%b", job, busy, out_a_vld); end
            end
        end
    endtask

    // Test sequence.
    initial begin
        for (int c = 0; c < NCYC; c++) begin
            expData[c] = '0;
            expVld[c]  = '0;
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0);
        test_reset();
        test_weight_load();
        test_skew();
        test_bubbles();
        test_ignored_inputs();
        test_reset_mid_job();
        test_backpressure();
        test_random_jobs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
